alu_serial_engine: RTL and testbench

Multi-cycle, bit-serial N-bit ALU engine built around the 1-bit ALU slice function set (AND, OR, ADD, SUB, SLT, NOR selected by a 4-bit `ALUs` code).
- Accepts a word-wide operation through a start/busy/done handshake.
- Processes one bit per clock, LSB first, carrying the slice carry between cycles.
- Assembles the word result, carry-out and zero flag.
- Acts as the sequencing master for the 1-bit slice: it supplies per-bit operands and control, and consumes the slice's sum and carry outputs.

---
 rtl/alu_serial_engine.sv | 175 +++++++++++++++++
 tb/tb_alu_serial_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_engine.sv
// Bit-serial WIDTH-bit ALU engine: one slice bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output V is built when ALU_SERIAL_V_EN is defined.
module alu_serial_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUs,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             C,
    output logic             Zero,
    output logic             err
`ifdef ALU_SERIAL_V_EN
    ,
    output logic             V
`endif
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    logic [1:0]       state;
    logic [3:0]       op;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;

    logic             is_arith;
    logic             is_addsub;
    logic             op_legal;
    logic             b_eff;
    logic             sum_bit;
    logic             carry_nxt;
    logic             slice_bit;
    logic             ovf;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] fin_result;
    logic             fin_c;

    // 1-bit slice on the current LSBs, plus the word-level values used at DONE entry.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_arith  = 1'b0;
        is_addsub = 1'b0;
        op_legal  = 1'b1;
        slice_bit = 1'b0;
        case (op)
            OP_AND: slice_bit = a_sr[0] & b_sr[0];
            OP_OR:  slice_bit = a_sr[0] | b_sr[0];
            OP_NOR: slice_bit = ~(a_sr[0] | b_sr[0]);
            OP_ADD, OP_SUB: begin
                is_arith  = 1'b1;
                is_addsub = 1'b1;
            end
            OP_SLT:  is_arith = 1'b1;
            default: op_legal = 1'b0;
        endcase

        b_eff     = b_sr[0] ^ ((op == OP_SUB) || (op == OP_SLT));
        sum_bit   = a_sr[0] ^ b_eff ^ carry;
        carry_nxt = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
        if (is_arith) begin
            slice_bit = sum_bit;
        end

        // On the last bit, carry-in vs carry-out of the MSB gives signed overflow.
        ovf     = carry ^ carry_nxt;
        res_nxt = {slice_bit, res_sr};

        fin_result = res_nxt;
        fin_c      = 1'b0;
        if (!op_legal) begin
            fin_result = '0;
        end else if (op == OP_SLT) begin
            fin_result = {{(WIDTH-1){1'b0}}, sum_bit ^ ovf};
        end else if (is_addsub) begin
            fin_c = carry_nxt;
        end
    end

    // Control FSM and architectural outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= OP_AND;
            idx    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            C      <= 1'b0;
            Zero   <= 1'b1;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        op    <= ALUs;
                        idx   <= '0;
                        carry <= (ALUs == OP_SUB) || (ALUs == OP_SLT);
                    end
                end
                S_RUN: begin
                    idx <= idx + IDX_W'(1);
                    if (is_arith) begin
                        carry <= carry_nxt;
                    end
                    if (idx == LAST_IDX) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        Result <= fin_result;
                        C      <= fin_c;
                        Zero   <= (fin_result == '0);
                        err    <= ~op_legal;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand and partial-result shift registers.
    // NOTE: these are reloaded on every accept before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt[WIDTH-1:1];
        end
    end

`ifdef ALU_SERIAL_V_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            V <= 1'b0;
        end else if (state == S_RUN && idx == LAST_IDX) begin
            V <= is_addsub & ovf;
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_engine.sv
// Directed self-checking bench for alu_serial_engine (WIDTH=8), hand-computed expected values.
module tb_alu_serial_engine;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALUs;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         C;
    logic         Zero;
    logic         err;
`ifdef ALU_SERIAL_V_EN
    logic         V;
`endif

    int total  = 0;
    int passed = 0;

    alu_serial_engine #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUs   (ALUs),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .C      (C),
        .Zero   (Zero),
        .err    (err)
`ifdef ALU_SERIAL_V_EN
        ,
        .V      (V)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for done, then check latency and results.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_z, input logic exp_err, input logic exp_v);
        int cyc;
        start = 1'b1;
        ALUs  = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        cyc = 0;
        for (int i = 1; i <= W + 4; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
        check({tag, ".lat"}, cyc, W);
        check({tag, ".res"}, 32'(Result), 32'(exp_r));
        check({tag, ".c"}, 32'(C), 32'(exp_c));
        check({tag, ".zero"}, 32'(Zero), 32'(exp_z));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
`ifdef ALU_SERIAL_V_EN
        check({tag, ".v"}, 32'(V), 32'(exp_v));
`else
        if (exp_v) begin
            // V is not observable in this build.
        end
`endif
        tick();
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        ALUs  = 4'd0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.res", 32'(Result), 32'd0);
        check("rst.c", 32'(C), 32'd0);
        check("rst.zero", 32'(Zero), 32'd1);
        check("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        //     tag        op     A      B      Result C     Z     err   V
        run_op("add_ovf", 4'd2,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_eq",  4'd6,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_neg", 4'd6,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_a",   4'd7,  8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf", 4'd7,  8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_no",  4'd7,  8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("and",     4'd0,  8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or",      4'd1,  8'hAA, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("nor",     4'd12, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("illegal", 4'd4,  8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("add_clr", 4'd2,  8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add_c",   4'd2,  8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-RUN with different operands must not disturb the op in flight.
        start = 1'b1;
        ALUs  = 4'd2;
        A     = 8'h10;
        B     = 8'h20;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        ALUs  = 4'd6;
        A     = 8'hFF;
        B     = 8'h77;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int i = 4; i <= W + 4; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
        check("midstart.lat", cyc, W);
        check("midstart.res", 32'(Result), 32'h30);
        check("midstart.zero", 32'(Zero), 32'd0);
        tick();
        tick();

        // Reset mid-RUN: aborts the op, no done is ever issued for it.
        start = 1'b1;
        ALUs  = 4'd1;
        A     = 8'h0F;
        B     = 8'hF0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.zero", 32'(Zero), 32'd1);
        check("abort.res", 32'(Result), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done) cyc++;
        end
        check("abort.nodone", cyc, 0);
        check("abort.idle", 32'(busy), 32'd0);

        run_op("post_rst", 4'd6, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
